// File: rtl/aiken_to_bcd_packer.sv
// Receive side of the BCD<->2421 (Aiken) digit path.
// Decodes 2421 codes to 8421 BCD and packs up to DIGITS digits MSD-first into
// one word, presented on a valid/ready output with a sticky illegal-code flag.
module aiken_to_bcd_packer #(
   parameter int DIGITS = 4,
   parameter int CNT_W  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_code,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic [CNT_W-1:0]      out_ndig,
   output logic                  out_err
);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_EMIT  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [4*DIGITS-1:0]  shreg_q, shreg_d;
   logic [CNT_W-1:0]     cnt_q,   cnt_d;
   logic                 err_q,   err_d;

   logic [3:0]           digit;
   logic                 illegal;

   // 2421 -> 8421 decode; illegal codes map to digit 0 and raise the flag
   always_comb begin
      digit   = 4'd0;
      illegal = 1'b0;
      if (in_code <= 4'd4) begin
         digit = in_code;
      end else if (in_code >= 4'd11) begin
         digit = in_code - 4'd6;
      end else begin
         illegal = 1'b1;
      end
   end

   // Next-state logic: accumulate digits, close the word, wait for the handshake
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         ST_ACCUM: begin
            if (in_valid) begin
               // Truncating the concatenation drops the oldest digit and also
               // covers DIGITS == 1, where no lower slice of shreg exists.
               shreg_d = (4*DIGITS)'({shreg_q, digit});
               cnt_d   = cnt_q + CNT_W'(1);
               err_d   = err_q | illegal;
               if (in_last || (cnt_d == CNT_W'(DIGITS))) begin
                  state_d = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               shreg_d = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = ST_ACCUM;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   // State register with synchronous active-low reset; reset drops any word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ACCUM;
         shreg_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Outputs: word fields are only exposed while a word is presented
   always_comb begin
      in_ready  = (state_q == ST_ACCUM);
      out_valid = (state_q == ST_EMIT);
      out_bcd   = out_valid ? shreg_q : '0;
      out_ndig  = out_valid ? cnt_q   : '0;
      out_err   = out_valid ? err_q   : 1'b0;
   end

endmodule

// File: tb/tb_aiken_to_bcd_packer.sv
// Self-checking bench for aiken_to_bcd_packer: directed scenarios followed by
// random traffic, all compared against a digit-level reference model.
module tb_aiken_to_bcd_packer;

   localparam int DIGITS = 4;
   localparam int CNT_W  = 3;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [3:0]          in_code;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [4*DIGITS-1:0] out_bcd;
   logic [CNT_W-1:0]    out_ndig;
   logic                out_err;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // Reference model state: packed value, digit count, error flag, word presented
   int unsigned m_val;
   int unsigned m_cnt;
   bit          m_err;
   bit          m_pend;

   aiken_to_bcd_packer #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_code   (in_code),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .out_ndig  (out_ndig),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Expected decode from the 2421 weight table
   function automatic void ref_decode(input int unsigned code, output int unsigned d, output bit bad);
      bad = 1'b0;
      d   = 0;
      case (code)
         0, 1, 2, 3, 4:       d = code;
         11, 12, 13, 14, 15:  d = code - 6;
         default:             bad = 1'b1;
      endcase
   endfunction

   task automatic model_clear();
      m_val  = 0;
      m_cnt  = 0;
      m_err  = 1'b0;
      m_pend = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".in_ready"},  32'(in_ready),  32'(!m_pend));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_pend));
      check({tag, ".out_bcd"},   32'(out_bcd),   m_pend ? m_val : 32'd0);
      check({tag, ".out_ndig"},  32'(out_ndig),  m_pend ? m_cnt : 32'd0);
      check({tag, ".out_err"},   32'(out_err),   32'(m_pend && m_err));
   endtask

   // One clock cycle, entered and left at a falling edge
   task automatic cycle(input string tag, input bit v, input int unsigned code, input bit last, input bit ordy);
      int unsigned d;
      bit          bad;
      in_valid  = v;
      in_code   = 4'(code);
      in_last   = last;
      out_ready = ordy;
      #1;
      check_outputs(tag);
      if (m_pend) begin
         if (ordy) model_clear();
      end else if (v) begin
         ref_decode(code, d, bad);
         m_val = m_val * 16 + d;
         m_cnt = m_cnt + 1;
         m_err = m_err | bad;
         if (last || m_cnt == DIGITS) m_pend = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag, input int unsigned n);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_code   = 4'd0;
      out_ready = 1'b0;
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
         check({tag, ".out_bcd"},   32'(out_bcd),   32'd0);
         check({tag, ".out_ndig"},  32'(out_ndig),  32'd0);
         check({tag, ".out_err"},   32'(out_err),   32'd0);
      end
      rst_n = 1'b1;
      model_clear();
   endtask

   initial begin
      model_clear();
      // Reset for two cycles, ready afterwards
      do_reset("reset", 2);
      check("reset.in_ready", 32'(in_ready), 32'd1);

      // Full word 1459, single-cycle out_valid
      cycle("full0", 1, 4'b0001, 0, 1);
      cycle("full1", 1, 4'b0100, 0, 1);
      cycle("full2", 1, 4'b1011, 0, 1);
      cycle("full3", 1, 4'b1111, 0, 1);
      cycle("full_emit", 0, 0, 0, 1);
      cycle("full_idle", 0, 0, 0, 1);

      // Early last: right-justified 0063
      cycle("early0", 1, 4'b1100, 0, 1);
      cycle("early1", 1, 4'b0011, 1, 1);
      cycle("early_emit", 0, 0, 0, 1);

      // Illegal code flags the word, next word starts clean
      cycle("ill0", 1, 4'b0010, 0, 1);
      cycle("ill1", 1, 4'b0110, 1, 1);
      cycle("ill_emit", 0, 0, 0, 1);
      cycle("clean0", 1, 4'b0000, 1, 1);
      cycle("clean_emit", 0, 0, 0, 1);

      // Backpressure with an input digit held pending
      cycle("bp0", 1, 4'b1110, 1, 0);
      for (int unsigned i = 0; i < 5; i++) cycle("bp_hold", 1, 4'b0001, 1, 0);
      cycle("bp_hs", 1, 4'b0001, 1, 1);
      cycle("bp_accept", 1, 4'b0001, 1, 1);
      cycle("bp_emit", 0, 0, 0, 1);

      // Partial word held while in_valid is low
      cycle("hold0", 1, 4'b1101, 0, 1);
      for (int unsigned i = 0; i < 3; i++) cycle("hold_idle", 0, 4'b1111, 1, 1);
      cycle("hold1", 1, 4'b0011, 1, 1);
      cycle("hold_emit", 0, 0, 0, 1);

      // Reset mid-word discards the partial digits
      cycle("mid0", 1, 4'b0001, 0, 1);
      cycle("mid1", 1, 4'b0010, 0, 1);
      do_reset("mid_reset", 1);
      cycle("mid_new", 1, 4'b1101, 1, 1);
      cycle("mid_emit", 0, 0, 0, 1);

      // Random traffic
      for (int unsigned i = 0; i < 300; i++) begin
         cycle("rand",
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 15),
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
